// File: rtl/rip_div_unit.sv
// ----------------------------------------------------------------------------
// rip_div_unit
//   Multi-cycle RV32M divider for DIV, DIVU, REM and REMU in the EX stage.
//   It accepts one operation, computes one quotient bit per cycle with a
//   radix-2 restoring sequence, and then returns one result. busy stalls
//   issue while an operation is in flight, and flush aborts it.
//
// Ports
//   clk       in   clock, rising edge
//   rstn      in   asynchronous reset, active-low
//   start     in   request, sampled only in IDLE
//   op        in   00=DIV 01=DIVU 10=REM 11=REMU, sampled with start
//   dividend  in   rs1 value, sampled with start
//   divisor   in   rs2 value, sampled with start
//   flush     in   abort current operation, back to IDLE on next edge
//   busy      out  high whenever state != IDLE
//   valid     out  one-cycle pulse in DONE, result is the accepted op's answer
//   result    out  registered result, held until the next DONE
// ----------------------------------------------------------------------------
module rip_div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            flush,
    output logic            busy,
    output logic            valid,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   quo_q, quo_d;     // dividend magnitude shifting out, quotient shifting in
    logic [XLEN-1:0]   rem_q, rem_d;     // partial remainder
    logic [XLEN-1:0]   dvs_q, dvs_d;     // divisor magnitude
    logic              is_rem_q, is_rem_d;
    logic              qneg_q, qneg_d;
    logic              rneg_q, rneg_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [XLEN-1:0]   prev_q, prev_d;   // result before the latest DONE update

    logic [XLEN-1:0]   min_int;
    logic              signed_op, rem_op, a_neg, b_neg, div_zero, ovf;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     shifted, trial;
    logic              ge;
    logic [XLEN-1:0]   rem_step, quo_step, q_signed, r_signed;

    // Operand decode for the request presented in IDLE.
    assign min_int   = {1'b1, {(XLEN-1){1'b0}}};
    assign signed_op = ~op[0];
    assign rem_op    = op[1];
    assign a_neg     = signed_op & dividend[XLEN-1];
    assign b_neg     = signed_op & divisor[XLEN-1];
    // Negating MIN_INT yields 2^(XLEN-1), which is the correct unsigned magnitude.
    assign a_mag     = a_neg ? (~dividend + 1'b1) : dividend;
    assign b_mag     = b_neg ? (~divisor + 1'b1) : divisor;
    assign div_zero  = (divisor == '0);
    assign ovf       = signed_op & (dividend == min_int) & (divisor == '1);

    // One restoring step: shift in the next dividend bit and subtract if it fits.
    // The extra bit keeps the trial compare exact for divisors near 2^XLEN.
    assign shifted   = {rem_q, quo_q[XLEN-1]};
    assign trial     = shifted - {1'b0, dvs_q};
    assign ge        = ~trial[XLEN];
    assign rem_step  = ge ? trial[XLEN-1:0] : shifted[XLEN-1:0];
    assign quo_step  = {quo_q[XLEN-2:0], ge};
    assign q_signed  = qneg_q ? (~quo_step + 1'b1) : quo_step;
    assign r_signed  = rneg_q ? (~rem_step + 1'b1) : rem_step;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        is_rem_d = is_rem_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        result_d = result_q;
        prev_d   = prev_q;
        if (flush) begin
            state_d = S_IDLE;
            // result was already loaded on entry to DONE; an abort there restores it.
            if (state_q == S_DONE) begin
                result_d = prev_q;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        is_rem_d = rem_op;
                        qneg_d   = a_neg ^ b_neg;
                        rneg_d   = a_neg;
                        quo_d    = a_mag;
                        rem_d    = '0;
                        dvs_d    = b_mag;
                        cnt_d    = '0;
                        if (div_zero) begin
                            state_d  = S_DONE;
                            prev_d   = result_q;
                            result_d = rem_op ? dividend : '1;
                        end else if (ovf) begin
                            state_d  = S_DONE;
                            prev_d   = result_q;
                            result_d = rem_op ? '0 : min_int;
                        end else begin
                            state_d  = S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    quo_d = quo_step;
                    rem_d = rem_step;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(XLEN - 1)) begin
                        state_d  = S_DONE;
                        prev_d   = result_q;
                        result_d = is_rem_q ? r_signed : q_signed;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            is_rem_q <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
            prev_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            is_rem_q <= is_rem_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
            prev_q   <= prev_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign valid  = (state_q == S_DONE) & ~flush;
    assign result = result_q;

endmodule

// File: tb/tb_rip_div_unit.sv
// ----------------------------------------------------------------------------
// tb_rip_div_unit
//   Scoreboard bench for rip_div_unit. Stimulus pushes the expected result
//   and its completion cycle. A negedge monitor pops one entry for every
//   valid pulse and compares both values.
// ----------------------------------------------------------------------------
module tb_rip_div_unit;

    localparam int XLEN = 32;

    logic            clk;
    logic            rstn;
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic            flush;
    logic            busy;
    logic            valid;
    logic [XLEN-1:0] result;

    typedef struct {
        logic [XLEN-1:0] res;
        int              cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   n_checks;
    int   n_pass;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    rip_div_unit #(.XLEN(XLEN)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .start    (start),
        .op       (op),
        .dividend (dividend),
        .divisor  (divisor),
        .flush    (flush),
        .busy     (busy),
        .valid    (valid),
        .result   (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_checks = n_checks + 1;
        if (act === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks = n_checks + 1;
                $display("FAIL unexpected_valid: result 0x%08h with no outstanding op (cycle %0d)", result, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", result, e.res);
                check("valid_cycle", XLEN'(cyc), XLEN'(e.cyc));
            end
        end
    end

    // Called one time unit after a rising edge. The current cyc is cycle 0
    // of the op. The task returns in the first IDLE cycle after DONE.
    task automatic run_op(input logic [1:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input logic [XLEN-1:0] exp, input int lat);
        sb.push_back('{res: exp, cyc: cyc + lat});
        start    = 1'b1;
        op       = o;
        dividend = a;
        divisor  = b;
        @(posedge clk); #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        op       = 2'($urandom_range(0, 3));
        repeat (lat) @(posedge clk);
        #1;
    endtask

    initial begin
        int c;
        cyc      = 0;
        n_checks = 0;
        n_pass   = 0;
        rstn     = 1'b0;
        start    = 1'b0;
        flush    = 1'b0;
        op       = 2'b00;
        dividend = '0;
        divisor  = '0;

        repeat (2) @(negedge clk);
        check("rst_busy", XLEN'(busy), '0);
        check("rst_valid", XLEN'(valid), '0);
        check("rst_result", result, '0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;

        // DIV -7/2 with explicit busy window checks
        c = cyc;
        sb.push_back('{res: 32'hFFFF_FFFD, cyc: c + 33});
        start = 1'b1; op = OP_DIV; dividend = 32'hFFFF_FFF9; divisor = 32'd2;
        @(posedge clk); #1;
        start = 1'b0; dividend = 32'h1234_5678; divisor = 32'h0000_0003;
        check("busy_c1", XLEN'(busy), 32'd1);
        repeat (32) @(posedge clk);
        #1;
        check("busy_c33", XLEN'(busy), 32'd1);
        @(posedge clk); #1;
        check("busy_c34", XLEN'(busy), '0);

        run_op(OP_REM,  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 33);
        run_op(OP_DIVU, 32'hFFFF_FFFF, 32'd0,        32'hFFFF_FFFF, 1);
        run_op(OP_REMU, 32'd5,         32'd0,        32'd5,         1);
        run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        1);
        run_op(OP_DIV,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
        run_op(OP_REM,  32'd7,         32'hFFFF_FFFE, 32'd1,        33);
        run_op(OP_DIVU, 32'h8000_0000, 32'd3,        32'h2AAA_AAAA, 33);
        run_op(OP_REMU, 32'h8000_0000, 32'd3,        32'd2,         33);
        run_op(OP_DIV,  32'h8000_0000, 32'd2,        32'hC000_0000, 33);
        run_op(OP_REM,  32'h8000_0000, 32'd3,        32'hFFFF_FFFE, 33);
        run_op(OP_DIV,  32'd0,         32'd0,        32'hFFFF_FFFF, 1);

        // DIVU 100/7 with start pulses while busy, in cycles 5 and 33
        c = cyc;
        sb.push_back('{res: 32'd14, cyc: c + 33});
        start = 1'b1; op = OP_DIVU; dividend = 32'd100; divisor = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1; op = OP_DIV; dividend = 32'd1; divisor = 32'd0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (27) @(posedge clk);
        #1;
        start = 1'b1; op = OP_DIVU; dividend = 32'd0; divisor = 32'd0;
        @(posedge clk); #1;
        start = 1'b0;
        check("ignored_start_idle", XLEN'(busy), '0);

        // REMU 100/7 flushed at cycle 10, then reissued at cycle 11
        c = cyc;
        start = 1'b1; op = OP_REMU; dividend = 32'd100; divisor = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        check("flush_busy_c10", XLEN'(busy), 32'd1);
        check("flush_valid_c10", XLEN'(valid), '0);
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_cycle", XLEN'(cyc - c), 32'd11);
        check("flush_busy_c11", XLEN'(busy), '0);
        check("flush_result_kept", result, 32'd14);
        run_op(OP_REMU, 32'd100, 32'd7, 32'd2, 33);

        // Flush combined with start in IDLE: flush wins
        flush = 1'b1; start = 1'b1; op = OP_DIVU; dividend = 32'd9; divisor = 32'd0;
        @(posedge clk); #1;
        flush = 1'b0; start = 1'b0;
        check("flush_start_idle", XLEN'(busy), '0);

        // Reset asserted at cycle 20 of a DIV
        c = cyc;
        start = 1'b1; op = OP_DIV; dividend = 32'd1000; divisor = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        check("pre_reset_busy", XLEN'(busy), 32'd1);
        rstn = 1'b0;
        #1;
        check("midrst_busy", XLEN'(busy), '0);
        check("midrst_valid", XLEN'(valid), '0);
        check("midrst_result", result, '0);
        @(posedge clk); #1;
        rstn = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("post_reset_busy", XLEN'(busy), '0);
        check("post_reset_result", result, '0);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", XLEN'(sb.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
